// File: rtl/pim_cfu_pkg.sv
// rtl/pim_cfu_pkg.sv - shared opcodes, FSM state type and popcount width helper for the PIM MAC CFU
package pim_cfu_pkg;

  localparam logic [2:0] OP_READ       = 3'd0;
  localparam logic [2:0] OP_WRITE      = 3'd1;
  localparam logic [2:0] OP_LOAD_PLANE = 3'd2;
  localparam logic [2:0] OP_MAC        = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  // A column of 2^awidth cells can count up to 2^awidth, which needs awidth+1 bits.
  function automatic int pcnt_width(input int awidth);
    return awidth + 1;
  endfunction

endpackage

// File: rtl/pim_adc_column.sv
// rtl/pim_adc_column.sv - one bit-line column: popcount of stored bits gated by the read word lines.
// Optional ADC clamp selected by PIM_ADC_SAT_EN.
module pim_adc_column
  import pim_cfu_pkg::*;
#(
  parameter int AWIDTH   = 5,
  parameter int ADC_BITS = 6,
  localparam int DEPTH   = 1 << AWIDTH,
  localparam int CW      = pcnt_width(AWIDTH)
) (
  input  logic [DEPTH-1:0] col,
  input  logic [DEPTH-1:0] rwl,
  output logic [CW-1:0]    adc
);

  logic [CW-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + CW'(col[k] & rwl[k]);
    end
  end

`ifdef PIM_ADC_SAT_EN
  localparam int SAT_MAX = (1 << ADC_BITS) - 1;

  always_comb begin
    adc = cnt;
    if (int'(cnt) > SAT_MAX) begin
      adc = CW'(SAT_MAX);
    end
  end
`else
  localparam int unused_adc_bits = ADC_BITS;

  assign adc = cnt;
`endif

endmodule

// File: rtl/pim_mac_cfu.sv
// rtl/pim_mac_cfu.sv - processing-in-memory bit-serial MAC custom function unit (top).
// Define PIM_ADC_SAT_EN to clamp each column ADC to ADC_BITS.
module pim_mac_cfu
  import pim_cfu_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int IBITS    = 4,
  parameter int ADC_BITS = 6,
  parameter int PWIDTH   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_payload_function_id,
  input  logic [PWIDTH-1:0] cmd_payload_inputs_0,
  input  logic [PWIDTH-1:0] cmd_payload_inputs_1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_payload_response_ok,
  output logic [DWIDTH-1:0] rsp_payload_outputs_0
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int CW    = pcnt_width(AWIDTH);

  state_t state, next_state;

  logic [DWIDTH-1:0] mem    [DEPTH];
  logic [DEPTH-1:0]  planes [16];
  logic [DWIDTH-1:0] acc, acc_next, partial, rsp_data;
  logic              rsp_ok;
  logic [3:0]        bit_idx;
  logic [2:0]        op;
  logic [AWIDTH-1:0] addr;
  logic              accept, addr_ok, plane_ok, legal, last_bit;
  logic [DEPTH-1:0]  rwl;
  logic [DEPTH-1:0]  col_bits [DWIDTH];
  logic [CW-1:0]     adc      [DWIDTH];
  logic              unused_cmd_bits;

  assign op              = cmd_payload_function_id[2:0];
  assign addr            = cmd_payload_inputs_1[AWIDTH-1:0];
  assign addr_ok         = cmd_payload_inputs_1 < PWIDTH'(DEPTH);
  assign plane_ok        = cmd_payload_inputs_1 < PWIDTH'(IBITS);
  assign cmd_ready       = (state == IDLE);
  assign accept          = cmd_valid && cmd_ready;
  assign last_bit        = (bit_idx == 4'(IBITS - 1));
  assign rwl             = planes[bit_idx];
  assign unused_cmd_bits = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_0};

  assign rsp_valid               = (state == RESP);
  assign rsp_payload_response_ok = rsp_ok;
  assign rsp_payload_outputs_0   = rsp_data;

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_READ, OP_WRITE: legal = addr_ok;
      OP_LOAD_PLANE:     legal = plane_ok;
      OP_MAC:            legal = 1'b1;
      default:           legal = 1'b0;
    endcase
  end

  // Transpose rows into bit-line columns for the per-column ADCs.
  always_comb begin
    for (int j = 0; j < DWIDTH; j++) begin
      for (int k = 0; k < DEPTH; k++) begin
        col_bits[j][k] = mem[k][j];
      end
    end
  end

  for (genvar j = 0; j < DWIDTH; j++) begin : g_col
    pim_adc_column #(
      .AWIDTH  (AWIDTH),
      .ADC_BITS(ADC_BITS)
    ) u_col (
      .col(col_bits[j]),
      .rwl(rwl),
      .adc(adc[j])
    );
  end

  // Column j carries weight 2^j, bit plane b carries weight 2^b.
  always_comb begin
    partial = '0;
    for (int j = 0; j < DWIDTH; j++) begin
      partial = partial + (DWIDTH'(adc[j]) << j);
    end
    acc_next = acc + (partial << bit_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (op == OP_MAC) ? EXEC : RESP;
      EXEC:    if (last_bit) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      bit_idx  <= '0;
      rsp_ok   <= 1'b0;
      rsp_data <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      for (int p = 0; p < 16; p++) planes[p] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_ok   <= legal;
            rsp_data <= '0;
            if (legal) begin
              case (op)
                OP_READ: rsp_data <= mem[addr];
                OP_WRITE: begin
                  mem[addr] <= cmd_payload_inputs_0[DWIDTH-1:0];
                  rsp_data  <= cmd_payload_inputs_0[DWIDTH-1:0];
                end
                OP_LOAD_PLANE: planes[cmd_payload_inputs_1[3:0]] <= cmd_payload_inputs_0[DEPTH-1:0];
                OP_MAC: begin
                  acc     <= '0;
                  bit_idx <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        EXEC: begin
          acc     <= acc_next;
          bit_idx <= bit_idx + 4'd1;
          if (last_bit) rsp_data <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pim_mac_cfu.sv
// tb/tb_pim_mac_cfu.sv - directed self-checking bench for pim_mac_cfu
module tb_pim_mac_cfu;

  localparam int DWIDTH   = 32;
  localparam int AWIDTH   = 5;
  localparam int IBITS    = 4;
  localparam int ADC_BITS = 2;
  localparam int PWIDTH   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [9:0]        fid;
  logic [PWIDTH-1:0] in0, in1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_ok;
  logic [DWIDTH-1:0] rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  pim_mac_cfu #(
    .DWIDTH  (DWIDTH),
    .AWIDTH  (AWIDTH),
    .IBITS   (IBITS),
    .ADC_BITS(ADC_BITS),
    .PWIDTH  (PWIDTH)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_payload_function_id(fid),
    .cmd_payload_inputs_0   (in0),
    .cmd_payload_inputs_1   (in1),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_payload_response_ok(rsp_ok),
    .rsp_payload_outputs_0  (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a0, input logic [31:0] a1);
    @(negedge clk);
    fid       = {7'h5A, op};
    in0       = a0;
    in1       = a1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] a0, input logic [31:0] a1,
                        output logic ok, output logic [31:0] data, output int lat);
    issue(op, a0, a1);
    wait_rsp(lat);
    ok   = rsp_ok;
    data = rsp_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        ok;
    logic [31:0] data;
    int          lat;
    logic        seen;
    logic [31:0] sat_exp;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    fid       = '0;
    in0       = '0;
    in1       = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_ok", rsp_ok, 0);
    check("reset_data", rsp_data, 0);

    do_cmd(3'd1, 32'hDEADBEEF, 3, ok, data, lat);
    check("write_ok", ok, 1);
    check("write_data", data, 32'hDEADBEEF);
    check("write_lat", lat, 1);
    do_cmd(3'd0, 0, 3, ok, data, lat);
    check("read_ok", ok, 1);
    check("read_data", data, 32'hDEADBEEF);
    check("read_lat", lat, 1);

    do_cmd(3'd5, 32'h1111, 3, ok, data, lat);
    check("ill_op_ok", ok, 0);
    check("ill_op_data", data, 0);
    do_cmd(3'd0, 0, 40, ok, data, lat);
    check("ill_addr_ok", ok, 0);
    check("ill_addr_data", data, 0);
    do_cmd(3'd2, 32'hFFFF_FFFF, 7, ok, data, lat);
    check("ill_plane_ok", ok, 0);
    check("ill_plane_data", data, 0);
    do_cmd(3'd1, 32'h1234, 35, ok, data, lat);
    check("ill_write_ok", ok, 0);
    do_cmd(3'd0, 0, 3, ok, data, lat);
    check("ill_readback", data, 32'hDEADBEEF);

    // a[0]=2, a[1]=1 -> 2*3 + 1*5 = 11
    do_cmd(3'd1, 3, 0, ok, data, lat);
    do_cmd(3'd1, 5, 1, ok, data, lat);
    do_cmd(3'd2, 32'h2, 0, ok, data, lat);
    check("load0_ok", ok, 1);
    do_cmd(3'd2, 32'h1, 1, ok, data, lat);
    do_cmd(3'd3, 0, 0, ok, data, lat);
    check("mac_ok", ok, 1);
    check("mac_data", data, 32'h0000000B);
    check("mac_lat", lat, 5);

    rsp_ready = 1'b0;
    issue(3'd0, 0, 1);
    wait_rsp(lat);
    check("bp_lat", lat, 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 5);
      check("bp_cmd_ready", cmd_ready, 0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_consumed", rsp_valid, 0);
    check("bp_cmd_ready_after", cmd_ready, 1);

    issue(3'd3, 0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check("abort_no_rsp", seen, 0);
    do_cmd(3'd0, 0, 3, ok, data, lat);
    check("abort_read3", data, 0);
    do_cmd(3'd0, 0, 1, ok, data, lat);
    check("abort_read1", data, 0);

`ifdef PIM_ADC_SAT_EN
    sat_exp = 32'd3;
`else
    sat_exp = 32'd32;
`endif
    for (int a = 0; a < 32; a++) do_cmd(3'd1, 1, a, ok, data, lat);
    do_cmd(3'd2, 32'hFFFF_FFFF, 0, ok, data, lat);
    do_cmd(3'd3, 0, 0, ok, data, lat);
    check("sat_data", data, sat_exp);
    check("sat_lat", lat, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
